// File: rtl/seven_seg_scanner_pkg.sv
// Shared constants and types for the multiplexed seven-segment scanner.
// Segment and anode constants are active-low; segment order is {g,f,e,d,c,b,a}.
package seven_seg_pkg;

  localparam int unsigned SEG_W   = 7;
  localparam int unsigned AN_W    = 4;
  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned IDX_W   = 2;

  localparam logic [SEG_W-1:0] SEG_0    = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1    = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2    = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3    = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4    = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5    = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6    = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7    = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8    = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9    = 7'b0010000;
  localparam logic [SEG_W-1:0] SEG_DASH = 7'b0111111;
  localparam logic [SEG_W-1:0] SEG_OFF  = 7'b1111111;

  localparam logic [AN_W-1:0] AN_OFF = 4'b1111;

  // Scan phase within a slot; BLANK is the ghosting guard interval.
  typedef logic [0:0] scan_state_t;
  localparam scan_state_t BLANK = 1'b0;
  localparam scan_state_t DRIVE = 1'b1;

  // Per-frame copy of the display request, taken at the start of the idx=0 slot.
  typedef struct packed {
    logic [DIGIT_W-1:0] digit1;
    logic [DIGIT_W-1:0] digit2;
    logic [DIGIT_W-1:0] digit3;
    logic [DIGIT_W-1:0] digit4;
    logic [AN_W-1:0]    blink;
  } frameSnap_t;

  // idx 0 is the leftmost digit, which sits on an[3].
  function automatic logic [AN_W-1:0] anodeFor(input logic [IDX_W-1:0] idx);
    return ~(AN_W'(4'b1000) >> idx);
  endfunction

endpackage

// File: rtl/seven_seg_scanner_if.sv
// Display request from the mode logic (digits, blink mask) and the board pin outputs.
interface seven_seg_scanner_if;
  import seven_seg_pkg::*;

  logic [DIGIT_W-1:0] digit1;
  logic [DIGIT_W-1:0] digit2;
  logic [DIGIT_W-1:0] digit3;
  logic [DIGIT_W-1:0] digit4;
  logic [AN_W-1:0]    blink;
  logic [AN_W-1:0]    an;
  logic [SEG_W-1:0]   seg;
  logic               dp;

  modport master (
    output digit1, digit2, digit3, digit4, blink,
    input  an, seg, dp
  );

  modport slave (
    input  digit1, digit2, digit3, digit4, blink,
    output an, seg, dp
  );
endinterface

// File: rtl/seven_seg_scanner_bcd_to_seg.sv
// Combinational BCD to active-low seven-segment decoder; codes 10-15 render as a dash.
module bcd_to_seg
  import seven_seg_pkg::*;
(
  input  logic [DIGIT_W-1:0] value,
  output logic [SEG_W-1:0]   seg_c
);

  always_comb begin
    seg_c = SEG_DASH;
    case (value)
      4'd0:    seg_c = SEG_0;
      4'd1:    seg_c = SEG_1;
      4'd2:    seg_c = SEG_2;
      4'd3:    seg_c = SEG_3;
      4'd4:    seg_c = SEG_4;
      4'd5:    seg_c = SEG_5;
      4'd6:    seg_c = SEG_6;
      4'd7:    seg_c = SEG_7;
      4'd8:    seg_c = SEG_8;
      4'd9:    seg_c = SEG_9;
      default: seg_c = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Four-digit time-multiplexed common-anode driver with per-slot guard blanking and blink.
// Build option: define LEADING_ZERO_BLANK_EN to blank digit1 when its frame value is 0.
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned SCAN_HZ      = 4000,
  parameter int unsigned BLANK_CYCLES = 64,
  parameter int unsigned BLINK_HZ     = 2
) (
  input logic               clk,
  input logic               rst_n,
  seven_seg_scanner_if.slave disp
);

  localparam int unsigned SLOT_CYCLES = CLK_HZ / SCAN_HZ;
  localparam int unsigned BLINK_HALF  = CLK_HZ / (2 * BLINK_HZ);
  localparam int unsigned SLOT_W      = $clog2(SLOT_CYCLES);
  localparam int unsigned BLINK_W     = $clog2(BLINK_HALF);

  logic [SLOT_W-1:0]  slotCnt,    slotCntNext;
  logic [IDX_W-1:0]   idx,        idxNext;
  logic [BLINK_W-1:0] blinkCnt,   blinkCntNext;
  logic               blinkPhase, blinkPhaseNext;
  logic               phaseCap,   phaseCapNext;
  frameSnap_t         snap,       snapNext;
  scan_state_t        state,      stateNext;
  logic [AN_W-1:0]    anReg,      anNext;
  logic [SEG_W-1:0]   segReg,     segNext;
  logic               dpReg;

  logic [DIGIT_W-1:0] selDigit;
  logic               selBlink;
  logic               hideSlot;
  logic               lzHide;
  logic [SEG_W-1:0]   decSeg;

  // Counters, frame snapshot and slot-start phase capture.
  always_comb begin
    slotCntNext    = slotCnt + SLOT_W'(1);
    idxNext        = idx;
    blinkCntNext   = blinkCnt + BLINK_W'(1);
    blinkPhaseNext = blinkPhase;
    phaseCapNext   = phaseCap;
    snapNext       = snap;

    if (slotCnt == SLOT_W'(SLOT_CYCLES - 1)) begin
      slotCntNext = '0;
      idxNext     = idx + IDX_W'(1);
    end

    if (blinkCnt == BLINK_W'(BLINK_HALF - 1)) begin
      blinkCntNext   = '0;
      blinkPhaseNext = ~blinkPhase;
    end

    // A toggle landing on the slot-start edge is already in blinkPhase here.
    if (slotCnt == '0) begin
      phaseCapNext = blinkPhase;
      if (idx == '0) begin
        snapNext.digit1 = disp.digit1;
        snapNext.digit2 = disp.digit2;
        snapNext.digit3 = disp.digit3;
        snapNext.digit4 = disp.digit4;
        snapNext.blink  = disp.blink;
      end
    end
  end

  // Digit and blink bit for the slot the outputs are about to show.
  always_comb begin
    selDigit = snapNext.digit1;
    selBlink = snapNext.blink[3];
    case (idxNext)
      2'd0: begin selDigit = snapNext.digit1; selBlink = snapNext.blink[3]; end
      2'd1: begin selDigit = snapNext.digit2; selBlink = snapNext.blink[2]; end
      2'd2: begin selDigit = snapNext.digit3; selBlink = snapNext.blink[1]; end
      2'd3: begin selDigit = snapNext.digit4; selBlink = snapNext.blink[0]; end
      default: begin selDigit = snapNext.digit1; selBlink = snapNext.blink[3]; end
    endcase
  end

  bcd_to_seg u_dec (
    .value (selDigit),
    .seg_c (decSeg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  assign lzHide = (idxNext == '0) && (snapNext.digit1 == '0);
`else
  assign lzHide = 1'b0;
`endif

  assign hideSlot = (selBlink && !phaseCapNext) || lzHide;

  // Slot FSM: phase follows the slot counter; outputs are computed for the next cycle.
  always_comb begin
    stateNext = state;
    anNext    = AN_OFF;
    segNext   = SEG_OFF;

    case (state)
      BLANK:   if (slotCntNext >= SLOT_W'(BLANK_CYCLES)) stateNext = DRIVE;
      DRIVE:   if (slotCntNext <  SLOT_W'(BLANK_CYCLES)) stateNext = BLANK;
      default: stateNext = BLANK;
    endcase

    if ((stateNext == DRIVE) && !hideSlot) begin
      anNext  = anodeFor(idxNext);
      segNext = decSeg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slotCnt    <= '0;
      idx        <= '0;
      blinkCnt   <= '0;
      blinkPhase <= 1'b1;
      phaseCap   <= 1'b1;
      snap       <= '0;
      state      <= BLANK;
      anReg      <= AN_OFF;
      segReg     <= SEG_OFF;
      dpReg      <= 1'b1;
    end else begin
      slotCnt    <= slotCntNext;
      idx        <= idxNext;
      blinkCnt   <= blinkCntNext;
      blinkPhase <= blinkPhaseNext;
      phaseCap   <= phaseCapNext;
      snap       <= snapNext;
      state      <= stateNext;
      anReg      <= anNext;
      segReg     <= segNext;
      dpReg      <= 1'b1;
    end
  end

  assign disp.an  = anReg;
  assign disp.seg = segReg;
  assign disp.dp  = dpReg;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner: directed vector table, hand sequences and a randomized
// run compared cycle-by-cycle against a frame/slot arithmetic model.
module tb_seven_seg_scanner;

  localparam int unsigned CLK_HZ       = 64000;
  localparam int unsigned SCAN_HZ      = 4000;
  localparam int unsigned BLANK_CYCLES = 2;
  localparam int unsigned BLINK_HZ     = 250;
  localparam int unsigned SLOT         = CLK_HZ / SCAN_HZ;
  localparam int unsigned BLINK_HALF   = CLK_HZ / (2 * BLINK_HZ);
  localparam int unsigned MAXCYC       = 4096;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seven_seg_scanner_if dispIf();

  seven_seg_scanner #(
    .CLK_HZ       (CLK_HZ),
    .SCAN_HZ      (SCAN_HZ),
    .BLANK_CYCLES (BLANK_CYCLES),
    .BLINK_HZ     (BLINK_HZ)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .disp  (dispIf)
  );

  int unsigned nChecks = 0;
  int unsigned nFails  = 0;
  int unsigned cyc     = 0;
  logic [19:0] inHist [MAXCYC];

  typedef struct {
    string       name;
    logic [3:0]  d1, d2, d3, d4, blk;
    int unsigned at;
    logic [3:0]  an;
    logic [6:0]  seg;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [10:0] got, input logic [10:0] want);
    nChecks++;
    if (got !== want) begin
      nFails++;
      $display("FAIL %s at cycle %0d: got %b, want %b", name, cyc, got, want);
    end
  endtask

  function automatic logic [6:0] glyphOf(input logic [3:0] v);
    case (v)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  // Expected {an,seg} in cycle t after reset release, from slot/frame arithmetic.
  function automatic logic [10:0] modelOut(input int unsigned t);
    int unsigned slot  = t / SLOT;
    int unsigned pos   = t % SLOT;
    int unsigned di    = slot % 4;
    int unsigned frame = (slot / 4) * 4 * SLOT;
    logic        phase = (((slot * SLOT) / BLINK_HALF) % 2) == 0;
    logic [19:0] s;
    logic [3:0]  dv [4];
    logic [3:0]  a;
    if (pos < BLANK_CYCLES) return {4'b1111, 7'b1111111};
    s = inHist[frame];
    dv[0] = s[19:16]; dv[1] = s[15:12]; dv[2] = s[11:8]; dv[3] = s[7:4];
    if (s[3 - di] && !phase) return {4'b1111, 7'b1111111};
`ifdef LEADING_ZERO_BLANK_EN
    if (di == 0 && dv[0] == 4'd0) return {4'b1111, 7'b1111111};
`endif
    a = 4'b1111;
    a[3 - di] = 1'b0;
    return {a, glyphOf(dv[di])};
  endfunction

  task automatic setInputs(input logic [3:0] d1, d2, d3, d4, blk);
    dispIf.digit1 = d1; dispIf.digit2 = d2; dispIf.digit3 = d3; dispIf.digit4 = d4;
    dispIf.blink  = blk;
  endtask

  // Leaves the bench at the falling edge of cycle 0 with reset just released.
  task automatic resetDut();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
  endtask

  task automatic stepCycle();
    if (cyc < MAXCYC)
      inHist[cyc] = {dispIf.digit1, dispIf.digit2, dispIf.digit3, dispIf.digit4, dispIf.blink};
    @(negedge clk);
    cyc++;
  endtask

  task automatic stepTo(input int unsigned t);
    while (cyc < t) stepCycle();
  endtask

  function automatic logic [10:0] dispOut();
    return {dispIf.an, dispIf.seg};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned lowCnt;
    int unsigned otherCnt;
    setInputs(4'd1, 4'd2, 4'd3, 4'd4, 4'b0000);

    vecs.push_back('{"rst_off",    4'd1, 4'd2, 4'd3, 4'd4, 4'b0000, 0,   4'b1111, 7'b1111111});
    vecs.push_back('{"guard0",     4'd1, 4'd2, 4'd3, 4'd4, 4'b0000, 1,   4'b1111, 7'b1111111});
    vecs.push_back('{"d1_first",   4'd1, 4'd2, 4'd3, 4'd4, 4'b0000, 2,   4'b0111, 7'b1111001});
    vecs.push_back('{"d1_last",    4'd1, 4'd2, 4'd3, 4'd4, 4'b0000, 15,  4'b0111, 7'b1111001});
    vecs.push_back('{"guard1a",    4'd1, 4'd2, 4'd3, 4'd4, 4'b0000, 16,  4'b1111, 7'b1111111});
    vecs.push_back('{"guard1b",    4'd1, 4'd2, 4'd3, 4'd4, 4'b0000, 17,  4'b1111, 7'b1111111});
    vecs.push_back('{"d2",         4'd1, 4'd2, 4'd3, 4'd4, 4'b0000, 18,  4'b1011, 7'b0100100});
    vecs.push_back('{"d3",         4'd1, 4'd2, 4'd3, 4'd4, 4'b0000, 34,  4'b1101, 7'b0110000});
    vecs.push_back('{"d4",         4'd1, 4'd2, 4'd3, 4'd4, 4'b0000, 50,  4'b1110, 7'b0011001});
    vecs.push_back('{"d4_end",     4'd1, 4'd2, 4'd3, 4'd4, 4'b0000, 63,  4'b1110, 7'b0011001});
    vecs.push_back('{"frame_wrap", 4'd1, 4'd2, 4'd3, 4'd4, 4'b0000, 64,  4'b1111, 7'b1111111});
    vecs.push_back('{"invalid12",  4'd1, 4'd12, 4'd3, 4'd4, 4'b0000, 20, 4'b1011, 7'b0111111});
    vecs.push_back('{"glyph9",     4'd9, 4'd8, 4'd7, 4'd6, 4'b0000, 2,   4'b0111, 7'b0010000});
    vecs.push_back('{"glyph8",     4'd9, 4'd8, 4'd7, 4'd6, 4'b0000, 20,  4'b1011, 7'b0000000});
    vecs.push_back('{"glyph6",     4'd9, 4'd8, 4'd7, 4'd6, 4'b0000, 60,  4'b1110, 7'b0000010});
    vecs.push_back('{"blink_vis",  4'd1, 4'd2, 4'd3, 4'd4, 4'b1000, 2,   4'b0111, 7'b1111001});
    vecs.push_back('{"blink_hid",  4'd1, 4'd2, 4'd3, 4'd4, 4'b1000, 130, 4'b1111, 7'b1111111});
    vecs.push_back('{"blink_oth",  4'd1, 4'd2, 4'd3, 4'd4, 4'b1000, 146, 4'b1011, 7'b0100100});
    vecs.push_back('{"blink_back", 4'd1, 4'd2, 4'd3, 4'd4, 4'b1000, 258, 4'b0111, 7'b1111001});
`ifdef LEADING_ZERO_BLANK_EN
    vecs.push_back('{"lead_zero",  4'd0, 4'd2, 4'd3, 4'd4, 4'b0000, 5,   4'b1111, 7'b1111111});
`else
    vecs.push_back('{"lead_zero",  4'd0, 4'd2, 4'd3, 4'd4, 4'b0000, 5,   4'b0111, 7'b1000000});
`endif
    vecs.push_back('{"lz_other",   4'd0, 4'd0, 4'd3, 4'd4, 4'b0000, 21,  4'b1011, 7'b1000000});

    // Reset state held with the clock running.
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_hold", dispOut(), {4'b1111, 7'b1111111});
    check("rst_dp", 11'(dispIf.dp), 11'd1);

    foreach (vecs[i]) begin
      setInputs(vecs[i].d1, vecs[i].d2, vecs[i].d3, vecs[i].d4, vecs[i].blk);
      resetDut();
      stepTo(vecs[i].at);
      check(vecs[i].name, dispOut(), {vecs[i].an, vecs[i].seg});
    end

    // Snapshot: a mid-frame change to digit4 waits for the next frame.
    setInputs(4'd1, 4'd2, 4'd3, 4'd4, 4'b0000);
    resetDut();
    stepTo(40);
    dispIf.digit4 = 4'd7;
    stepTo(50);
    check("snap_old", dispOut(), {4'b1110, 7'b0011001});
    stepTo(114);
    check("snap_new", dispOut(), {4'b1110, 7'b1111000});
    check("snap_dp", 11'(dispIf.dp), 11'd1);

    // Asynchronous reset in the middle of a driven slot.
    resetDut();
    stepTo(25);
    check("pre_rst", dispOut(), {4'b1011, 7'b0100100});
    #1 rst_n = 1'b0;
    #1;
    check("async_rst", dispOut(), {4'b1111, 7'b1111111});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    check("restart_blank", dispOut(), {4'b1111, 7'b1111111});
    stepTo(1);
    check("restart_guard", dispOut(), {4'b1111, 7'b1111111});
    stepTo(2);
    check("restart_idx0", dispOut(), {4'b0111, 7'b1111001});

    // Blink span: digit1 stays dark for a full hidden phase, others keep scanning.
    setInputs(4'd1, 4'd2, 4'd3, 4'd4, 4'b1000);
    resetDut();
    lowCnt = 0;
    otherCnt = 0;
    while (cyc < 512) begin
      check("blink_model", dispOut(), modelOut(cyc));
      if (cyc >= 128 && cyc < 256) begin
        if (!dispIf.an[3]) lowCnt++;
        if (dispIf.an == 4'b1011) otherCnt++;
      end
      stepCycle();
    end
    check("blink_span_dark", 11'(lowCnt), 11'd0);
    check("blink_span_scan", 11'(otherCnt), 11'd28);

    // Randomized inputs against the model.
    setInputs(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
    resetDut();
    while (cyc < 2000) begin
      check("rand_model", dispOut(), modelOut(cyc));
      if ($urandom_range(0, 11) == 0) begin
        case ($urandom_range(0, 4))
          0: dispIf.digit1 = 4'($urandom);
          1: dispIf.digit2 = 4'($urandom);
          2: dispIf.digit3 = 4'($urandom);
          3: dispIf.digit4 = 4'($urandom);
          default: dispIf.blink = 4'($urandom);
        endcase
      end
      stepCycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
